bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter_rr_pick.sv | 25 ++
 rtl/bus_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: source/enable/index sizes, arbiter state encoding,
// and the enable-word and owner-index types used across the bus datapath.
package bus_pkg;

   localparam int N_BUS_SRC = 24;
   localparam int BUS_EN_W  = 32;
   localparam int BUS_ID_W  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   typedef logic [BUS_EN_W-1:0] bus_en_t;
   typedef logic [BUS_ID_W-1:0] bus_id_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesting agents and the bus arbiter.
// Handshake: req is a level held by a source for as long as it wants the bus;
// it owns the bus in every cycle where grant_valid=1 and grant_id names it.
interface bus_arbiter_if
   import bus_pkg::*;
#(
   parameter int N_SRC = N_BUS_SRC,
   parameter int EN_W  = BUS_EN_W,
   parameter int ID_W  = BUS_ID_W
) ();

   logic [N_SRC-1:0] req;
   logic [EN_W-1:0]  Bus_enable;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic             preempt;
   arb_state_t       dbg_state;

   modport master (
      input  req,
      output Bus_enable, grant_valid, grant_id, preempt, dbg_state
   );

   modport slave (
      output req,
      input  Bus_enable, grant_valid, grant_id, preempt, dbg_state
   );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit after ptr, wrapping.
// Also usable for memory-port arbitration.
module rr_pick #(
   parameter int N    = 24,
   parameter int ID_W = 5
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            found,
   output logic [ID_W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // ptr itself is checked last, so the previous winner has lowest priority
      for (int i = 1; i <= N; i++) begin
         if (!found && req[(int'(ptr) + i) % N]) begin
            found = 1'b1;
            idx   = ID_W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle idle turnaround between owners.
// Define BUS_ARB_TIMEOUT_EN to add tenure limiting with a preempt pulse.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int N_SRC      = N_BUS_SRC,
   parameter int EN_W       = BUS_EN_W,
   parameter int ID_W       = BUS_ID_W,
   parameter int MAX_TENURE = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   bus_arbiter_if.master bus
);

   arb_state_t      state_q, state_n;
   logic [ID_W-1:0] ptr_q, ptr_n;
   logic [EN_W-1:0] en_q, en_n;
   logic [ID_W-1:0] id_q, id_n;
   logic            valid_q, valid_n;
   logic            pre_q, pre_n;
   logic            pick_found;
   logic [ID_W-1:0] pick_idx;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);
   logic [7:0]       tenure_q, tenure_n;
   logic [N_SRC-1:0] others;

   assign others = bus.req & ~(N_SRC'(1) << id_q);
`endif

   rr_pick #(.N(N_SRC), .ID_W(ID_W)) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_n = state_q;
      ptr_n   = ptr_q;
      en_n    = en_q;
      id_n    = id_q;
      valid_n = valid_q;
      pre_n   = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      tenure_n = tenure_q;
`endif
      case (state_q)
         IDLE, TURN: begin
            if (pick_found) begin
               state_n = GRANT;
               en_n    = EN_W'(1) << pick_idx;
               id_n    = pick_idx;
               valid_n = 1'b1;
               ptr_n   = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
               tenure_n = '0;
`endif
            end else begin
               state_n = IDLE;
               en_n    = '0;
               id_n    = '0;
               valid_n = 1'b0;
            end
         end
         GRANT: begin
            // A voluntary release wins over a timeout in the same cycle
            if (!bus.req[id_q]) begin
               state_n = TURN;
               en_n    = '0;
               id_n    = '0;
               valid_n = 1'b0;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (tenure_q == TEN_LAST && |others) begin
               state_n = TURN;
               en_n    = '0;
               id_n    = '0;
               valid_n = 1'b0;
               pre_n   = 1'b1;
            end else if (tenure_q != TEN_LAST) begin
               tenure_n = tenure_q + 8'd1;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            en_n    = '0;
            id_n    = '0;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= ID_W'(N_SRC - 1);
         en_q    <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         pre_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         tenure_q <= '0;
`endif
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         en_q    <= en_n;
         id_q    <= id_n;
         valid_q <= valid_n;
         pre_q   <= pre_n;
`ifdef BUS_ARB_TIMEOUT_EN
         tenure_q <= tenure_n;
`endif
      end
   end

   assign bus.Bus_enable  = en_q;
   assign bus.grant_id    = id_q;
   assign bus.grant_valid = valid_q;
`ifdef BUS_ARB_TIMEOUT_EN
   assign bus.preempt     = pre_q;
`else
   assign bus.preempt     = 1'b0;
`endif
   assign bus.dbg_state   = state_q;

`ifndef BUS_ARB_TIMEOUT_EN
   logic unused_pre;
   assign unused_pre = pre_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, checked
// against an owner-level reference model through an expected-output queue.
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int N      = N_BUS_SRC;
   localparam int EW     = BUS_EN_W;
   localparam int IW     = BUS_ID_W;
   localparam int MAXTEN = 4;
   localparam int XW     = EW + IW + 2;

   logic clk = 1'b0;
   logic rst_n;

   bus_arbiter_if #(.N_SRC(N), .EN_W(EW), .ID_W(IW)) bus_if ();

   bus_arbiter #(.N_SRC(N), .EN_W(EW), .ID_W(IW), .MAX_TENURE(MAXTEN)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   // expected word: {preempt, grant_valid, grant_id, Bus_enable}
   logic [XW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // reference model: who owns the bus, who won last, how long the owner has held it
   int m_owner = -1;
   int m_last  = N - 1;
   int m_ten   = 0;
   bit m_pre   = 1'b0;

   task automatic model_step(input logic [N-1:0] r, input logic rn);
      bit timeout_on;
      logic [N-1:0] rest;
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_on = 1'b1;
`else
      timeout_on = 1'b0;
`endif
      m_pre = 1'b0;
      if (!rn) begin
         m_owner = -1;
         m_last  = N - 1;
         m_ten   = 0;
      end else if (m_owner >= 0) begin
         rest = r;
         rest[m_owner] = 1'b0;
         if (!r[m_owner]) begin
            m_owner = -1;
         end else if (timeout_on && m_ten == MAXTEN - 1 && rest != '0) begin
            m_owner = -1;
            m_pre   = 1'b1;
         end else if (m_ten < MAXTEN - 1) begin
            m_ten++;
         end
      end else begin
         for (int i = 1; i <= N; i++) begin
            if (m_owner < 0 && r[(m_last + i) % N]) begin
               m_owner = (m_last + i) % N;
            end
         end
         if (m_owner >= 0) begin
            m_last = m_owner;
            m_ten  = 0;
         end
      end
   endtask

   function automatic logic [XW-1:0] model_word();
      logic [EW-1:0] e;
      logic [IW-1:0] id;
      e  = '0;
      id = '0;
      if (m_owner >= 0) begin
         e[m_owner] = 1'b1;
         id = IW'(m_owner);
      end
      return {m_pre, (m_owner >= 0), id, e};
   endfunction

   task automatic step(input logic [N-1:0] r, input logic rn);
      bus_if.req = r;
      rst_n = rn;
      model_step(r, rn);
      exp_q.push_back(model_word());
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: outputs are presented every cycle, compared just after the edge
   initial begin
      logic [XW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bus_enable", bus_if.Bus_enable, e[EW-1:0]);
            check("grant_id", EW'(bus_if.grant_id), EW'(e[EW+IW-1:EW]));
            check("grant_valid", EW'(bus_if.grant_valid), EW'(e[EW+IW]));
            check("preempt", EW'(bus_if.preempt), EW'(e[EW+IW+1]));
            check("onehot", EW'($countones(bus_if.Bus_enable) <= 1), EW'(1));
            check("id_range", EW'(int'(bus_if.grant_id) < N), EW'(1));
         end
      end
   end

   logic [N-1:0] all_req;
   logic [N-1:0] r;

   initial begin
      all_req = '1;
      // reset with source 0 requesting, then grant
      repeat (3) step(24'h000001, 1'b0);
      repeat (3) step(24'h000001, 1'b1);
      // source 0 owns, source 2 waits; drop source 0
      repeat (3) step(24'h000005, 1'b1);
      repeat (4) step(24'h000004, 1'b1);
      step(24'h000000, 1'b1);
      // all requesting, each owner releases after one grant cycle
      step(24'h000000, 1'b0);
      for (int c = 0; c < 2 * N + 4; c++) begin
         r = all_req;
         if (m_owner >= 0) r[m_owner] = 1'b0;
         step(r, 1'b1);
      end
      // top source alone, then wrap to 0
      step(24'h000000, 1'b0);
      repeat (3) step(24'h800000, 1'b1);
      repeat (4) step(24'h000001, 1'b1);
      // reset while source 7 owns the bus
      step(24'h000000, 1'b0);
      repeat (3) step(24'h000080, 1'b1);
      step(24'h000092, 1'b1);
      step(24'h000092, 1'b0);
      repeat (3) step(24'h000092, 1'b1);
      // tenure limit with a competitor, then a lone holder
      step(24'h000000, 1'b0);
      repeat (30) step(24'h000003, 1'b1);
      repeat (2) step(24'h000000, 1'b1);
      repeat (25) step(24'h000001, 1'b1);
      // random traffic with occasional resets
      r = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) r = N'($urandom() & $urandom() & $urandom());
         if (m_owner >= 0 && $urandom_range(0, 3) == 0) r[m_owner] = 1'b0;
         step(r, ($urandom_range(0, 60) != 0));
      end
      for (int c = 0; c < 5 && exp_q.size() > 0; c++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
